// File: rtl/loop_echo_responder.sv
// Far-end echo partner of the transceiver loop interface: buffers received
// pattern words in a FIFO and writes them back, optionally inverted, in order.
module loop_echo_responder #(
   parameter int DATA_WIDTH      = 56,
   parameter int FIFO_ADDR_WIDTH = 3,
   parameter int CNT_WIDTH       = 16
) (
   input  logic                       i_clk,
   input  logic                       i_arst,
   input  logic                       i_enable,
   input  logic                       i_invert,
   input  logic                       i_clr_cnt,
   input  logic                       i_rx_valid,
   input  logic [DATA_WIDTH-1:0]      i_rx_data,
   output logic                       o_rx_rd,
   input  logic                       i_tx_rdy,
   output logic                       o_tx_wr,
   output logic [DATA_WIDTH-1:0]      o_tx_data,
   output logic [FIFO_ADDR_WIDTH:0]   o_level,
   output logic                       o_busy,
   output logic [CNT_WIDTH-1:0]       o_rx_cnt,
   output logic [CNT_WIDTH-1:0]       o_echo_cnt,
   output logic                       o_full_seen
);
   // state    | meaning
   // RX_IDLE  | wait for enable, rx word and FIFO space
   // RX_POP   | pop strobe to rx, word written into FIFO
   // RX_GAP   | let the transceiver drop valid before the next pop
   // TX_IDLE  | wait for a buffered word
   // TX_LOAD  | head word addressed in the FIFO RAM
   // TX_WRITE | wait for tx ready, then hold the write strobe for one cycle
   // TX_GAP   | one idle cycle after each write
   localparam int AW = FIFO_ADDR_WIDTH;
   localparam int DEPTH = 2 ** AW;
   localparam logic [AW:0] LVL_FULL = (AW + 1)'(DEPTH);

   typedef enum logic [1:0] {RX_IDLE, RX_POP, RX_GAP} rx_state_t;
   typedef enum logic [1:0] {TX_IDLE, TX_LOAD, TX_WRITE, TX_GAP} tx_state_t;

   rx_state_t                r_rx_state, w_rx_nxt;
   tx_state_t                r_tx_state, w_tx_nxt;
   logic [1:0]               r_rst_sync;
   logic                     w_rst;
   logic [DATA_WIDTH-1:0]    r_mem [DEPTH];
   logic [AW:0]              r_wr_ptr, r_rd_ptr, w_wr_ptr_nxt, w_rd_ptr_nxt;
   logic [AW:0]              r_level;
   logic                     w_full, w_empty, w_wr_en, w_fire;
   logic                     r_rx_rd, r_tx_wr, r_busy, r_full_seen;
   logic [DATA_WIDTH-1:0]    r_tx_data;
   logic [CNT_WIDTH-1:0]     r_rx_cnt, r_echo_cnt;

   // Reset asserts immediately but releases only after two clean clock edges.
   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) r_rst_sync <= 2'b11;
      else        r_rst_sync <= {r_rst_sync[0], 1'b0};
   end
   assign w_rst = r_rst_sync[1];

   assign w_full  = (r_level == LVL_FULL);
   assign w_empty = (r_level == '0);
   assign w_wr_en = (r_rx_state == RX_POP);
   // The write strobe is registered, so the ready decision is taken one cycle early.
   assign w_fire  = i_tx_rdy & ((r_tx_state == TX_LOAD) |
                                ((r_tx_state == TX_WRITE) & ~r_tx_wr));
   assign w_wr_ptr_nxt = r_wr_ptr + (AW + 1)'(w_wr_en);
   assign w_rd_ptr_nxt = r_rd_ptr + (AW + 1)'(w_fire);

   always_comb begin
      w_rx_nxt = r_rx_state;
      case (r_rx_state)
         RX_IDLE: if (i_enable & i_rx_valid & ~w_full) w_rx_nxt = RX_POP;
         RX_POP:  w_rx_nxt = RX_GAP;
         RX_GAP:  w_rx_nxt = RX_IDLE;
         default: w_rx_nxt = RX_IDLE;
      endcase
   end

   always_comb begin
      w_tx_nxt = r_tx_state;
      case (r_tx_state)
         TX_IDLE:  if (~w_empty) w_tx_nxt = TX_LOAD;
         TX_LOAD:  w_tx_nxt = TX_WRITE;
         TX_WRITE: if (r_tx_wr) w_tx_nxt = TX_GAP;
         TX_GAP:   w_tx_nxt = TX_IDLE;
         default:  w_tx_nxt = TX_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= i_rx_data ^ {DATA_WIDTH{i_invert}};
   end

   always_ff @(posedge i_clk or posedge w_rst) begin
      if (w_rst) begin
         r_rx_state  <= RX_IDLE;
         r_tx_state  <= TX_IDLE;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_level     <= '0;
         r_rx_rd     <= 1'b0;
         r_tx_wr     <= 1'b0;
         r_tx_data   <= '0;
         r_busy      <= 1'b0;
         r_rx_cnt    <= '0;
         r_echo_cnt  <= '0;
         r_full_seen <= 1'b0;
      end else begin
         r_rx_state <= w_rx_nxt;
         r_tx_state <= w_tx_nxt;
         r_wr_ptr   <= w_wr_ptr_nxt;
         r_rd_ptr   <= w_rd_ptr_nxt;
         r_level    <= w_wr_ptr_nxt - w_rd_ptr_nxt;
         r_rx_rd    <= (w_rx_nxt == RX_POP);
         r_tx_wr    <= w_fire;
         if (w_fire) r_tx_data <= r_mem[r_rd_ptr[AW-1:0]];
         r_busy     <= (w_wr_ptr_nxt != w_rd_ptr_nxt) | (w_rx_nxt != RX_IDLE) |
                       (w_tx_nxt != TX_IDLE);
         if (i_clr_cnt)    r_rx_cnt <= '0;
         else if (w_wr_en) r_rx_cnt <= r_rx_cnt + CNT_WIDTH'(1);
         if (i_clr_cnt)    r_echo_cnt <= '0;
         else if (w_fire)  r_echo_cnt <= r_echo_cnt + CNT_WIDTH'(1);
         if (i_clr_cnt)    r_full_seen <= 1'b0;
         else if (i_enable & i_rx_valid & w_full) r_full_seen <= 1'b1;
      end
   end

   assign o_rx_rd     = r_rx_rd;
   assign o_tx_wr     = r_tx_wr;
   assign o_tx_data   = r_tx_data;
   assign o_level     = r_level;
   assign o_busy      = r_busy;
   assign o_rx_cnt    = r_rx_cnt;
   assign o_echo_cnt  = r_echo_cnt;
   assign o_full_seen = r_full_seen;

endmodule

// File: tb/tb_loop_echo_responder.sv
// Scoreboard bench for loop_echo_responder: a modelled rx transceiver feeds words,
// a tx monitor checks every echoed word against the expected-order queue.
module tb_loop_echo_responder;
   localparam int DW = 56;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          i_arst, i_enable, i_invert, i_clr_cnt, i_rx_valid, i_tx_rdy;
   logic [DW-1:0] i_rx_data;
   logic          o_rx_rd, o_tx_wr, o_busy, o_full_seen;
   logic [DW-1:0] o_tx_data;
   logic [3:0]    o_level;
   logic [CW-1:0] o_rx_cnt, o_echo_cnt;

   loop_echo_responder #(.DATA_WIDTH(DW), .FIFO_ADDR_WIDTH(3), .CNT_WIDTH(CW)) dut (
      .i_clk(clk), .i_arst(i_arst), .i_enable(i_enable), .i_invert(i_invert),
      .i_clr_cnt(i_clr_cnt), .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data),
      .o_rx_rd(o_rx_rd), .i_tx_rdy(i_tx_rdy), .o_tx_wr(o_tx_wr), .o_tx_data(o_tx_data),
      .o_level(o_level), .o_busy(o_busy), .o_rx_cnt(o_rx_cnt), .o_echo_cnt(o_echo_cnt),
      .o_full_seen(o_full_seen));

   always #5 clk = ~clk;

   int total = 0, bad = 0;
   int cyc = 0;
   int n_pop = 0, n_wr = 0, n_fed = 0;
   int last_rd_cyc = -100, last_wr_cyc = -100;
   logic [DW-1:0] last_tx_data = '0;
   logic [DW-1:0] rx_q[$];
   logic [DW-1:0] exp_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic drive_rx();
      i_rx_valid = (rx_q.size() > 0);
      i_rx_data  = (rx_q.size() > 0) ? rx_q[0] : '0;
   endtask

   task automatic push(input logic [DW-1:0] w);
      rx_q.push_back(w);
      n_fed++;
      drive_rx();
   endtask

   task automatic push_rand();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      push(r[DW-1:0]);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input int budget, input bit need_rx_empty);
      int k;
      k = 0;
      while (k < budget && !(o_busy === 1'b0 && exp_q.size() == 0 &&
                             (!need_rx_empty || rx_q.size() == 0))) begin
         step(1);
         k++;
      end
      check("idle_reached", 64'(k < budget), 64'd1);
   endtask

   task automatic check_counts(input string tag);
      check({tag, "_rx_cnt"}, 64'(o_rx_cnt), 64'(n_fed % 16));
      check({tag, "_echo_cnt"}, 64'(o_echo_cnt), 64'(n_fed % 16));
      check({tag, "_level"}, 64'(o_level), 64'd0);
   endtask

   // Receive transceiver model: the head word leaves only after a pop strobe.
   initial forever begin
      @(negedge clk);
      if (o_rx_rd === 1'b1) begin
         n_pop++;
         check("rd_spacing", 64'(cyc - last_rd_cyc >= 3), 64'd1);
         last_rd_cyc = cyc;
         check("rd_with_valid", 64'(rx_q.size() > 0), 64'd1);
         if (rx_q.size() > 0) begin
            exp_q.push_back(rx_q[0] ^ {DW{i_invert}});
            @(posedge clk);
            #1;
            void'(rx_q.pop_front());
            drive_rx();
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (o_tx_wr === 1'b1) begin
         n_wr++;
         last_wr_cyc = cyc;
         last_tx_data = o_tx_data;
         check("tx_expected", 64'(exp_q.size() > 0), 64'd1);
         if (exp_q.size() > 0) check("tx_data", 64'(o_tx_data), 64'(exp_q.pop_front()));
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int p0, w0, viol;
      i_arst = 1'b1; i_enable = 1'b0; i_invert = 1'b0; i_clr_cnt = 1'b0; i_tx_rdy = 1'b0;
      drive_rx();
      step(3);
      check("rst_rx_rd", 64'(o_rx_rd), 64'd0);
      check("rst_tx_wr", 64'(o_tx_wr), 64'd0);
      check("rst_tx_data", 64'(o_tx_data), 64'd0);
      check("rst_level", 64'(o_level), 64'd0);
      check("rst_busy", 64'(o_busy), 64'd0);
      check("rst_rx_cnt", 64'(o_rx_cnt), 64'd0);
      check("rst_echo_cnt", 64'(o_echo_cnt), 64'd0);
      check("rst_full_seen", 64'(o_full_seen), 64'd0);
      i_arst = 1'b0;
      step(4);
      check("post_rst_busy", 64'(o_busy), 64'd0);

      // single echo with the documented pop-to-write latency
      i_enable = 1'b1; i_tx_rdy = 1'b1;
      w0 = n_wr;
      push(56'h00123456789ABC);
      wait_idle(100, 1'b1);
      check("single_writes", 64'(n_wr - w0), 64'd1);
      check("single_latency", 64'(last_wr_cyc - last_rd_cyc), 64'd3);
      check("single_data", 64'(last_tx_data), 64'h00123456789ABC);
      check_counts("single");

      i_invert = 1'b1;
      push(56'h00FF00FF00FF00);
      wait_idle(100, 1'b1);
      check("invert_data", 64'(last_tx_data), 64'hFF00FF00FF00FF);
      i_invert = 1'b0;
      check_counts("invert");

      // backpressure until the FIFO is full
      i_tx_rdy = 1'b0;
      p0 = n_pop; w0 = n_wr;
      repeat (10) push_rand();
      step(60);
      check("full_pops", 64'(n_pop - p0), 64'd8);
      check("full_level", 64'(o_level), 64'd8);
      check("full_seen", 64'(o_full_seen), 64'd1);
      check("full_rx_left", 64'(rx_q.size()), 64'd2);
      check("full_busy", 64'(o_busy), 64'd1);
      i_tx_rdy = 1'b1;
      wait_idle(400, 1'b1);
      check("drain_writes", 64'(n_wr - w0), 64'd10);
      check("drain_pops", 64'(n_pop - p0), 64'd10);
      check("drain_full_sticky", 64'(o_full_seen), 64'd1);
      check_counts("drain");

      i_clr_cnt = 1'b1;
      step(1);
      i_clr_cnt = 1'b0;
      n_fed = 0;
      check("clr_rx_cnt", 64'(o_rx_cnt), 64'd0);
      check("clr_echo_cnt", 64'(o_echo_cnt), 64'd0);
      check("clr_full_seen", 64'(o_full_seen), 64'd0);

      // disable while words are buffered
      i_tx_rdy = 1'b0;
      repeat (4) push_rand();
      step(20);
      check("dis_level", 64'(o_level), 64'd4);
      i_enable = 1'b0;
      p0 = n_pop; w0 = n_wr;
      repeat (3) push_rand();
      i_tx_rdy = 1'b1;
      wait_idle(300, 1'b0);
      check("dis_writes", 64'(n_wr - w0), 64'd4);
      check("dis_no_pops", 64'(n_pop - p0), 64'd0);
      check("dis_level_end", 64'(o_level), 64'd0);
      check("dis_rx_left", 64'(rx_q.size()), 64'd3);
      i_enable = 1'b1;
      wait_idle(300, 1'b1);
      check_counts("dis");

      // randomized ready/enable/invert traffic
      w0 = n_wr;
      p0 = n_fed;
      for (int k = 0; k < 300; k++) begin
         if (k % 7 == 0 && n_fed - p0 < 40) push_rand();
         i_tx_rdy = 1'($urandom_range(0, 1));
         i_enable = ($urandom_range(0, 3) != 0);
         i_invert = 1'($urandom_range(0, 1));
         step(1);
      end
      i_enable = 1'b1; i_tx_rdy = 1'b1; i_invert = 1'b0;
      wait_idle(1000, 1'b1);
      check("rand_writes", 64'(n_wr - w0), 64'(n_fed - p0));
      check_counts("rand");

      // counter wrap at the 4-bit bench width
      i_clr_cnt = 1'b1;
      step(1);
      i_clr_cnt = 1'b0;
      n_fed = 0;
      repeat (15) push_rand();
      wait_idle(400, 1'b1);
      check("wrap_pre_echo", 64'(o_echo_cnt), 64'd15);
      push_rand();
      wait_idle(100, 1'b1);
      check("wrap_echo_zero", 64'(o_echo_cnt), 64'd0);
      check("wrap_rx_zero", 64'(o_rx_cnt), 64'd0);

      // clear held across a pop and an echo: counters never leave 0
      i_clr_cnt = 1'b1;
      w0 = n_wr;
      viol = 0;
      push_rand();
      for (int k = 0; k < 40; k++) begin
         step(1);
         if (o_rx_cnt !== '0 || o_echo_cnt !== '0) viol++;
      end
      check("clr_wins", 64'(viol), 64'd0);
      check("clr_echo_done", 64'(n_wr - w0), 64'd1);
      i_clr_cnt = 1'b0;
      n_fed = 0;
      step(2);
      check("clr_after_rx", 64'(o_rx_cnt), 64'd0);

      // reset while tx waits in WRITE with three words queued
      i_tx_rdy = 1'b0;
      repeat (3) push_rand();
      step(20);
      check("prerst_level", 64'(o_level), 64'd3);
      i_arst = 1'b1;
      #1;
      check("midrst_tx_wr", 64'(o_tx_wr), 64'd0);
      check("midrst_level", 64'(o_level), 64'd0);
      check("midrst_rx_cnt", 64'(o_rx_cnt), 64'd0);
      check("midrst_echo_cnt", 64'(o_echo_cnt), 64'd0);
      exp_q.delete();
      n_fed = 0;
      i_tx_rdy = 1'b1;
      push(56'hA5A5_5A5A_0F0F_F0);
      step(2);
      i_arst = 1'b0;
      step(1);
      check("rel_no_rd", 64'(o_rx_rd), 64'd0);
      check("rel_no_wr", 64'(o_tx_wr), 64'd0);
      wait_idle(200, 1'b1);
      check("rel_last_data", 64'(last_tx_data), 64'hA5A55A5A0F0FF0);
      check_counts("rel");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/loop_echo_responder.md
Name: loop_echo_responder

Overview:
- Far-end partner of the loop interface in the transceiver test core.
- Pops test patterns from the receiving transceiver's user port and buffers them in a FIFO.
- Writes each buffered pattern back through the transmitting transceiver, optionally bit-inverted, which closes the PC-driven pattern loop across the LVDS link.
- Exposes echo statistics for the status bank.

Parameters:
DATA_WIDTH, 56, width of one pattern word.
FIFO_ADDR_WIDTH, 3, FIFO depth = 2**FIFO_ADDR_WIDTH words (default 8).
CNT_WIDTH, 16, width of the echo and receive counters.

Ports:
i_clk  in  1  system clock
i_arst  in  1  asynchronous reset, active-high
i_enable  in  1  1 = responder active; 0 = no new reads, FIFO drains
i_invert  in  1  1 = echo ~data, sampled when the word is written into the FIFO
i_clr_cnt  in  1  synchronous clear of both counters and the sticky flag
i_rx_valid  in  1  receive transceiver holds a word
i_rx_data  in  DATA_WIDTH  receive word, valid while i_rx_valid=1
o_rx_rd  out  1  one-cycle pop strobe to the receive transceiver
i_tx_rdy  in  1  transmit transceiver accepts a word
o_tx_wr  out  1  one-cycle write strobe to the transmit transceiver
o_tx_data  out  DATA_WIDTH  word to transmit, valid while o_tx_wr=1
o_level  out  FIFO_ADDR_WIDTH+1  current FIFO fill level
o_busy  out  1  FIFO not empty, or either FSM not in IDLE
o_rx_cnt  out  CNT_WIDTH  words popped from rx
o_echo_cnt  out  CNT_WIDTH  words written to tx
o_full_seen  out  1  sticky: i_rx_valid=1 while FIFO full and enabled

Behaviour:
- Reset (async assert, sync release via the team's async_reset): all outputs 0; FIFO empty; both FSMs in IDLE; o_tx_data=0.
- All outputs are registered.
- RX FSM, states IDLE, POP, GAP:
  - IDLE->POP when i_enable & i_rx_valid & ~full.
  - In POP: o_rx_rd=1 for exactly one cycle; i_rx_data (xor {DATA_WIDTH{i_invert}}) is written into the FIFO in the same cycle; o_rx_cnt increments.
  - POP->GAP unconditionally. GAP->IDLE after one cycle. The GAP gives the transceiver time to drop valid, so at most one pop per 3 cycles.
- TX FSM, states IDLE, LOAD, WRITE, GAP:
  - IDLE->LOAD when the FIFO is not empty.
  - LOAD: FIFO read (synchronous RAM, 1-cycle latency).
  - LOAD->WRITE. In WRITE: wait until i_tx_rdy=1, then o_tx_wr=1 for one cycle with o_tx_data = head word; o_echo_cnt increments; FIFO read pointer advances.
  - WRITE->GAP->IDLE.
  - o_tx_data holds its last value otherwise.
- Latency: a word popped in cycle t with the tx idle and i_tx_rdy=1 gives o_tx_wr in cycle t+3.
- FIFO:
  - Simultaneous write and read in one cycle: o_level unchanged, both pointers advance.
  - Pointers wrap modulo depth; the extra MSB distinguishes full from empty.
  - Full: rx stays in IDLE and sets o_full_seen if i_rx_valid=1. No word is ever lost or overwritten.
  - Empty: tx stays in IDLE.
- i_enable=0:
  - An in-progress POP/GAP sequence completes.
  - No new pop starts.
  - The tx side continues draining.
- Order is preserved: words are echoed strictly in arrival order.
- Counters wrap from 2**CNT_WIDTH-1 to 0.
- i_clr_cnt clears o_rx_cnt, o_echo_cnt and o_full_seen next cycle. If i_clr_cnt coincides with an increment event, clear wins and the counter reads 0.
- Reset mid-operation: FIFO contents are discarded; no strobe is issued in the cycle after release.

Test Plan:
- Single echo: enable=1, invert=0, rx word 0x00_1234_5678_9ABC, tx_rdy=1 -> one o_rx_rd pulse; o_tx_wr 3 cycles later with o_tx_data=0x00123456789ABC; rx_cnt=1, echo_cnt=1, busy returns to 0.
- Invert: invert=1, rx word 0x00FF00FF00FF00 -> o_tx_data=0xFF00FF00FF00FF.
- Backpressure/full: tx_rdy=0, feed 10 words (i_rx_valid held) -> exactly 8 pops, o_level=8, o_full_seen=1. Then tx_rdy=1 -> 8 writes in original order; o_level returns to 0; rx resumes and pops the remaining 2.
- Disable mid-stream: 4 words buffered with tx_rdy=0, then enable=0 and tx_rdy=1 -> 4 writes, zero further o_rx_rd pulses.
- Wrap/clear: preset via 65535 echoes (or CNT_WIDTH=4 with 15 echoes), one more -> echo_cnt=0. Pulse i_clr_cnt together with an echo -> counters read 0.
- Reset mid-transfer: assert i_arst while tx is in WRITE with 3 words queued -> o_tx_wr=0, o_level=0, counters 0; no strobe in the first cycle after release.
